// File: rtl/h_mux4way_rr_if.sv
// h_mux4way_rr_if: four-producer/one-consumer valid/ready bus; H_MUX4WAY_PACKET_LOCK_EN adds in_last/out_last
interface h_mux4way_rr_if #(
  parameter int WIDTH = 16
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;
`ifdef H_MUX4WAY_PACKET_LOCK_EN
  logic [3:0]         in_last;
  logic               out_last;
  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );
  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
`else
  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
`endif
endinterface

// File: rtl/h_mux4way_rr.sv
// h_mux4way_rr: 4-to-1 round-robin gathering mux with one output register; H_MUX4WAY_PACKET_LOCK_EN enables packet locking
module h_mux4way_rr #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  h_mux4way_rr_if.master bus
);
  typedef enum logic {EMPTY, FULL} occ_t;
  occ_t             occ, occ_nx;
  logic [1:0]       ptr, ptr_nx, g;
  logic [3:0]       req;
  logic             hit, free, xfer;
  logic [WIDTH-1:0] sel_data;
`ifdef H_MUX4WAY_PACKET_LOCK_EN
  typedef enum logic {FREE_ARB, LOCKED} lock_t;
  lock_t      lock, lock_nx;
  logic [1:0] lock_ch;
  logic       last_g;
  assign req    = (lock == LOCKED) ? bus.in_valid & (4'b0001 << lock_ch) : bus.in_valid;
  assign last_g = bus.in_last[g];
`else
  assign req = bus.in_valid;
`endif
  assign free          = (occ == EMPTY) | bus.out_ready;
  assign bus.out_valid = occ == FULL;
  // Iterating downward leaves the lowest rotated offset from ptr as the winner
  always_comb begin
    g   = ptr;
    hit = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) begin
        g   = ptr + 2'(k);
        hit = 1'b1;
      end
  end
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < 4; k++)
      if (g == 2'(k)) sel_data = bus.in_data[k*WIDTH +: WIDTH];
  end
  assign xfer         = rst_n & free & hit;
  assign bus.in_ready = xfer ? 4'b0001 << g : 4'b0000;
  always_comb begin
    occ_nx = xfer ? FULL : bus.out_ready ? EMPTY : occ;
`ifdef H_MUX4WAY_PACKET_LOCK_EN
    lock_nx = xfer ? (last_g ? FREE_ARB : LOCKED) : lock;
    ptr_nx  = (xfer & last_g) ? g + 2'd1 : ptr;
`else
    ptr_nx  = xfer ? g + 2'd1 : ptr;
`endif
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      occ          <= EMPTY;
      ptr          <= '0;
      bus.out_data <= '0;
      bus.out_sel  <= '0;
    end else begin
      occ <= occ_nx;
      ptr <= ptr_nx;
      if (xfer) begin
        bus.out_data <= sel_data;
        bus.out_sel  <= g;
      end
    end
`ifdef H_MUX4WAY_PACKET_LOCK_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      lock         <= FREE_ARB;
      lock_ch      <= '0;
      bus.out_last <= 1'b0;
    end else begin
      lock <= lock_nx;
      if (xfer) begin
        lock_ch      <= g;
        bus.out_last <= last_g;
      end
    end
`endif
endmodule

// File: tb/tb_h_mux4way_rr.sv
// tb_h_mux4way_rr: table-driven directed check of h_mux4way_rr arbitration, backpressure and reset
module tb_h_mux4way_rr;
  localparam logic [63:0] RR = 64'h000D_000C_000B_000A;
  localparam logic [63:0] BP = 64'h000D_1234_000B_000A;
  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [63:0] d;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [15:0] od;
    logic [1:0]  os;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  vec_t tbl [23];
  h_mux4way_rr_if #(.WIDTH(16)) bus ();
  h_mux4way_rr #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic step(input vec_t t, input string nm);
    @(negedge clk);
    rst_n         = t.rst;
    bus.in_valid  = t.v;
    bus.in_data   = t.d;
    bus.out_ready = t.ordy;
    #1 chk({nm, ".in_ready"}, 32'(bus.in_ready), 32'(t.rdy));
    @(posedge clk);
    #1;
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'(t.ov));
    chk({nm, ".out_data"}, 32'(bus.out_data), 32'(t.od));
    chk({nm, ".out_sel"}, 32'(bus.out_sel), 32'(t.os));
  endtask
`ifdef H_MUX4WAY_PACKET_LOCK_EN
  task automatic step_l(input logic [3:0] v, input logic [63:0] d, input logic [3:0] last,
                        input logic [3:0] rdy, input logic [15:0] od, input logic [1:0] os,
                        input logic ol, input string nm);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.out_ready = 1'b1;
    #1 chk({nm, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
    @(posedge clk);
    #1;
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, ".out_data"}, 32'(bus.out_data), 32'(od));
    chk({nm, ".out_sel"}, 32'(bus.out_sel), 32'(os));
    chk({nm, ".out_last"}, 32'(bus.out_last), 32'(ol));
  endtask
`endif
  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'h0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef H_MUX4WAY_PACKET_LOCK_EN
    bus.in_last   = 4'hf;
`endif
    tbl[0]  = '{1'b0, 4'hf, RR, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
    tbl[1]  = '{1'b0, 4'hf, RR, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
    tbl[2]  = '{1'b0, 4'hf, RR, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
    tbl[3]  = '{1'b1, 4'hf, RR, 1'b1, 4'b0001, 1'b1, 16'h000A, 2'd0};
    tbl[4]  = '{1'b1, 4'hf, RR, 1'b1, 4'b0010, 1'b1, 16'h000B, 2'd1};
    tbl[5]  = '{1'b1, 4'hf, RR, 1'b1, 4'b0100, 1'b1, 16'h000C, 2'd2};
    tbl[6]  = '{1'b1, 4'hf, RR, 1'b1, 4'b1000, 1'b1, 16'h000D, 2'd3};
    tbl[7]  = '{1'b1, 4'hf, RR, 1'b1, 4'b0001, 1'b1, 16'h000A, 2'd0};
    tbl[8]  = '{1'b1, 4'h0, RR, 1'b1, 4'b0000, 1'b0, 16'h000A, 2'd0};
    tbl[9]  = '{1'b1, 4'h4, BP, 1'b0, 4'b0100, 1'b1, 16'h1234, 2'd2};
    for (int i = 10; i < 15; i++) tbl[i] = '{1'b1, 4'h4, BP, 1'b0, 4'b0000, 1'b1, 16'h1234, 2'd2};
    tbl[15] = '{1'b1, 4'h0, BP, 1'b1, 4'b0000, 1'b0, 16'h1234, 2'd2};
    tbl[16] = '{1'b1, 4'ha, RR, 1'b1, 4'b1000, 1'b1, 16'h000D, 2'd3};
    tbl[17] = '{1'b1, 4'ha, RR, 1'b1, 4'b0010, 1'b1, 16'h000B, 2'd1};
    tbl[18] = '{1'b1, 4'ha, RR, 1'b1, 4'b1000, 1'b1, 16'h000D, 2'd3};
    tbl[19] = '{1'b1, 4'h0, RR, 1'b1, 4'b0000, 1'b0, 16'h000D, 2'd3};
    tbl[20] = '{1'b1, 4'h4, BP, 1'b0, 4'b0100, 1'b1, 16'h1234, 2'd2};
    tbl[21] = '{1'b0, 4'hf, BP, 1'b0, 4'b0000, 1'b0, 16'h0000, 2'd0};
    tbl[22] = '{1'b1, 4'hf, RR, 1'b1, 4'b0001, 1'b1, 16'h000A, 2'd0};
    for (int i = 0; i < 23; i++) step(tbl[i], $sformatf("vec%0d", i));
`ifdef H_MUX4WAY_PACKET_LOCK_EN
    step_l(4'h3, 64'h000D_000C_0011_000A, 4'b0000, 4'b0010, 16'h0011, 2'd1, 1'b0, "lock0");
    step_l(4'h3, 64'h000D_000C_0022_000A, 4'b0000, 4'b0010, 16'h0022, 2'd1, 1'b0, "lock1");
    step_l(4'h3, 64'h000D_000C_0033_000A, 4'b0010, 4'b0010, 16'h0033, 2'd1, 1'b1, "lock2");
    step_l(4'h3, 64'h000D_000C_0044_000A, 4'b0000, 4'b0001, 16'h000A, 2'd0, 1'b0, "lock3");
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
